// File: rtl/sfx_pkg.sv
// Shared definitions for the buzzer arbiter: source codes, priorities, tone table, FSM encodings.
package sfx_pkg;

    typedef enum logic [2:0] {
        SRC_NONE    = 3'd0,
        SRC_CLICK   = 3'd1,
        SRC_PERFECT = 3'd2,
        SRC_GOOD    = 3'd3,
        SRC_MISS    = 3'd4,
        SRC_JINGLE  = 3'd5
    } src_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // Half-period counter must hold 113636 (220 Hz at 50 MHz), hence 17 bits.
    localparam int HP_W = 17;

    localparam int F_CLICK   = 32'd2000;
    localparam int F_PERFECT = 32'd1047;
    localparam int F_GOOD    = 32'd784;
    localparam int F_MISS    = 32'd220;

    function automatic int jingle_freq(input logic [1:0] idx);
        case (idx)
            2'd0:    return 32'd523;
            2'd1:    return 32'd659;
            2'd2:    return 32'd784;
            2'd3:    return 32'd1047;
            default: return 32'd523;
        endcase
    endfunction

    // Perfect and good share a level so a newer one replaces the older in the pending slot.
    function automatic logic [2:0] src_prio(input src_e src);
        case (src)
            SRC_CLICK:             return 3'd1;
            SRC_PERFECT, SRC_GOOD: return 3'd2;
            SRC_MISS:              return 3'd3;
            SRC_JINGLE:            return 3'd4;
            default:               return 3'd0;
        endcase
    endfunction

    function automatic logic pend_accept(input logic slot_valid, input src_e slot_src, input src_e new_src);
        if (new_src == SRC_NONE) begin
            return 1'b0;
        end else begin
            return !slot_valid || (src_prio(new_src) >= src_prio(slot_src));
        end
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: restarts low on i_Start, toggles every i_Hp cycles, held low when stopped.
module sfx_tone_gen
    import sfx_pkg::*;
(
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Start,
    input  logic            i_Stop,
    input  logic [HP_W-1:0] i_Hp,
    input  logic            i_Mute,
    output logic            o_Wave
);

    localparam logic [HP_W-1:0] HP_ONE = {{(HP_W-1){1'b0}}, 1'b1};

    logic            active_r;
    logic            active_nxt_s;
    logic [HP_W-1:0] hp_r;
    logic [HP_W-1:0] hp_nxt_s;
    logic [HP_W-1:0] cnt_r;
    logic [HP_W-1:0] cnt_nxt_s;
    logic            phase_r;
    logic            phase_nxt_s;
    logic            wave_r;

    // Next values of the half-period counter and wave phase
    always_comb begin
        active_nxt_s = active_r;
        hp_nxt_s     = hp_r;
        cnt_nxt_s    = cnt_r;
        phase_nxt_s  = phase_r;
        if (i_Start) begin
            active_nxt_s = 1'b1;
            hp_nxt_s     = i_Hp;
            cnt_nxt_s    = '0;
            phase_nxt_s  = 1'b0;
        end else if (i_Stop) begin
            active_nxt_s = 1'b0;
            cnt_nxt_s    = '0;
            phase_nxt_s  = 1'b0;
        end else if (active_r) begin
            if (cnt_r == hp_r - HP_ONE) begin
                cnt_nxt_s   = '0;
                phase_nxt_s = ~phase_r;
            end else begin
                cnt_nxt_s   = cnt_r + HP_ONE;
            end
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Phase keeps running under mute; only the pin copy is gated
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            active_r <= 1'b0;
            hp_r     <= '0;
            cnt_r    <= '0;
            phase_r  <= 1'b0;
            wave_r   <= 1'b0;
        end else begin
            active_r <= active_nxt_s;
            hp_r     <= hp_nxt_s;
            cnt_r    <= cnt_nxt_s;
            phase_r  <= phase_nxt_s;
            wave_r   <= phase_nxt_s & ~i_Mute;
        end
    end

    assign o_Wave = wave_r;

endmodule

// File: rtl/sfx_arbiter.sv
// Buzzer arbiter: fixed-priority selection with preemption, one-deep pending slot and timed tones.
module sfx_arbiter
    import sfx_pkg::*;
#(
    parameter int CLK_HZ      = 32'd50_000_000,
    parameter int DUR_HIT_MS  = 32'd60,
    parameter int DUR_MISS_MS = 32'd200,
    parameter int DUR_CLK_MS  = 32'd20,
    parameter int NOTE_MS     = 32'd150,
    parameter int GAP_MS      = 32'd10
)
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Game_Cmd,
    input  logic       i_Click,
    input  logic       i_Jingle,
    input  logic       i_Mute,
    output logic       o_Buzzer,
    output logic       o_Playing,
    output logic [2:0] o_Cur_Src,
    output logic       o_Pend_Valid
);

    localparam logic [15:0]     MS_LAST   = 16'(CLK_HZ / 32'd1000 - 32'd1);
    localparam logic [HP_W-1:0] HP_CLICK  = HP_W'(CLK_HZ / (32'd2 * F_CLICK));
    localparam logic [HP_W-1:0] HP_PERF   = HP_W'(CLK_HZ / (32'd2 * F_PERFECT));
    localparam logic [HP_W-1:0] HP_GOOD   = HP_W'(CLK_HZ / (32'd2 * F_GOOD));
    localparam logic [HP_W-1:0] HP_MISS   = HP_W'(CLK_HZ / (32'd2 * F_MISS));
    localparam logic [HP_W-1:0] HP_J0     = HP_W'(CLK_HZ / (32'd2 * jingle_freq(2'd0)));
    localparam logic [HP_W-1:0] HP_J1     = HP_W'(CLK_HZ / (32'd2 * jingle_freq(2'd1)));
    localparam logic [HP_W-1:0] HP_J2     = HP_W'(CLK_HZ / (32'd2 * jingle_freq(2'd2)));
    localparam logic [HP_W-1:0] HP_J3     = HP_W'(CLK_HZ / (32'd2 * jingle_freq(2'd3)));
    localparam logic [7:0]      HIT_LAST  = 8'(DUR_HIT_MS - 32'd1);
    localparam logic [7:0]      MISS_LAST = 8'(DUR_MISS_MS - 32'd1);
    localparam logic [7:0]      CLK_LAST  = 8'(DUR_CLK_MS - 32'd1);
    localparam logic [7:0]      NOTE_LAST = 8'(NOTE_MS - 32'd1);
    localparam logic [7:0]      GAP_LAST  = 8'(GAP_MS - 32'd1);

    logic [1:0]      state_r, state_nxt_s;
    src_e            cur_src_r, cur_nxt_s;
    logic [1:0]      note_r, note_nxt_s;
    logic            pend_valid_r, pend_v_nxt_s;
    src_e            pend_src_r, pend_src_nxt_s;
    logic [15:0]     pre_r, pre_nxt_s;
    logic [7:0]      ms_r, ms_nxt_s;
    logic            playing_r;

    src_e            cmd_src_s, top_src_s, sec_src_s, cand_src_s, merge_src_s, start_src_s;
    logic            merge_v_s, restart_jingle_s, preempt_s;
    logic            tick_s, expire_s, gap_done_s, start_s, stop_s;
    logic [1:0]      start_note_s;
    logic [7:0]      dur_last_s;
    logic [HP_W-1:0] hp_sel_s;

    // Decode requests into the highest and next-highest source of this cycle
    always_comb begin
        case (i_Game_Cmd)
            2'd1:    cmd_src_s = SRC_PERFECT;
            2'd2:    cmd_src_s = SRC_GOOD;
            2'd3:    cmd_src_s = SRC_MISS;
            default: cmd_src_s = SRC_NONE;
        endcase
        if (i_Jingle) begin
            top_src_s = SRC_JINGLE;
            sec_src_s = (cmd_src_s != SRC_NONE) ? cmd_src_s : (i_Click ? SRC_CLICK : SRC_NONE);
        end else if (cmd_src_s != SRC_NONE) begin
            top_src_s = cmd_src_s;
            sec_src_s = i_Click ? SRC_CLICK : SRC_NONE;
        end else begin
            top_src_s = i_Click ? SRC_CLICK : SRC_NONE;
            sec_src_s = SRC_NONE;
        end
        restart_jingle_s = (top_src_s == SRC_JINGLE) && (cur_src_r == SRC_JINGLE);
        preempt_s        = src_prio(top_src_s) > src_prio(cur_src_r);
    end

    // Ms prescaler tick, per-source duration and expiry detection
    always_comb begin
        tick_s = (pre_r == MS_LAST);
        case (cur_src_r)
            SRC_CLICK:             dur_last_s = CLK_LAST;
            SRC_PERFECT, SRC_GOOD: dur_last_s = HIT_LAST;
            SRC_MISS:              dur_last_s = MISS_LAST;
            SRC_JINGLE:            dur_last_s = NOTE_LAST;
            default:               dur_last_s = 8'd0;
        endcase
        expire_s   = (state_r == S_PLAY) && tick_s && (ms_r == dur_last_s);
        gap_done_s = (state_r == S_GAP) && tick_s && (ms_r == GAP_LAST);
    end

    // Pick the request offered to the pending slot and merge it with the slot contents
    always_comb begin
        case (state_r)
            S_IDLE:  cand_src_s = sec_src_s;
            S_PLAY:  cand_src_s = (restart_jingle_s || preempt_s) ? sec_src_s : top_src_s;
            S_GAP:   cand_src_s = top_src_s;
            default: cand_src_s = SRC_NONE;
        endcase
        if (pend_accept(pend_valid_r, pend_src_r, cand_src_s)) begin
            merge_v_s   = 1'b1;
            merge_src_s = cand_src_s;
        end else begin
            merge_v_s   = pend_valid_r;
            merge_src_s = pend_src_r;
        end
    end

    // FSM next state, tone start/stop and counter restart
    always_comb begin
        state_nxt_s    = state_r;
        cur_nxt_s      = cur_src_r;
        note_nxt_s     = note_r;
        pend_v_nxt_s   = merge_v_s;
        pend_src_nxt_s = merge_src_s;
        pre_nxt_s      = tick_s ? 16'd0 : pre_r + 16'd1;
        ms_nxt_s       = tick_s ? ms_r + 8'd1 : ms_r;
        stop_s         = 1'b0;
        start_src_s    = SRC_NONE;
        start_note_s   = 2'd0;
        case (state_r)
            S_IDLE: begin
                start_src_s = top_src_s;
            end
            S_PLAY: begin
                if (restart_jingle_s || preempt_s) begin
                    start_src_s = top_src_s;
                end else if (expire_s && (cur_src_r == SRC_JINGLE) && (note_r != 2'd3)) begin
                    start_src_s  = SRC_JINGLE;
                    start_note_s = note_r + 2'd1;
                end else if (expire_s) begin
                    state_nxt_s = S_GAP;
                    cur_nxt_s   = SRC_NONE;
                    stop_s      = 1'b1;
                    pre_nxt_s   = 16'd0;
                    ms_nxt_s    = 8'd0;
                end else begin
                    state_nxt_s = S_PLAY;
                end
            end
            S_GAP: begin
                if (gap_done_s && merge_v_s) begin
                    start_src_s    = merge_src_s;
                    pend_v_nxt_s   = 1'b0;
                    pend_src_nxt_s = SRC_NONE;
                end else if (gap_done_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_GAP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cur_nxt_s   = SRC_NONE;
                stop_s      = 1'b1;
            end
        endcase
        start_s = (start_src_s != SRC_NONE);
        if (start_s) begin
            state_nxt_s = S_PLAY;
            cur_nxt_s   = start_src_s;
            note_nxt_s  = start_note_s;
            pre_nxt_s   = 16'd0;
            ms_nxt_s    = 8'd0;
        end else begin
            note_nxt_s  = note_r;
        end
    end

    // Half-period for the tone being started
    always_comb begin
        case (start_src_s)
            SRC_CLICK:   hp_sel_s = HP_CLICK;
            SRC_PERFECT: hp_sel_s = HP_PERF;
            SRC_GOOD:    hp_sel_s = HP_GOOD;
            SRC_MISS:    hp_sel_s = HP_MISS;
            SRC_JINGLE: begin
                case (start_note_s)
                    2'd0:    hp_sel_s = HP_J0;
                    2'd1:    hp_sel_s = HP_J1;
                    2'd2:    hp_sel_s = HP_J2;
                    default: hp_sel_s = HP_J3;
                endcase
            end
            default:     hp_sel_s = HP_CLICK;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_r      <= S_IDLE;
            cur_src_r    <= SRC_NONE;
            note_r       <= 2'd0;
            pend_valid_r <= 1'b0;
            pend_src_r   <= SRC_NONE;
            pre_r        <= 16'd0;
            ms_r         <= 8'd0;
            playing_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cur_src_r    <= cur_nxt_s;
            note_r       <= note_nxt_s;
            pend_valid_r <= pend_v_nxt_s;
            pend_src_r   <= pend_src_nxt_s;
            pre_r        <= pre_nxt_s;
            ms_r         <= ms_nxt_s;
            playing_r    <= (cur_nxt_s != SRC_NONE);
        end
    end

    sfx_tone_gen u_tone (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Start (start_s),
        .i_Stop  (stop_s),
        .i_Hp    (hp_sel_s),
        .i_Mute  (i_Mute),
        .o_Wave  (o_Buzzer)
    );

    assign o_Playing    = playing_r;
    assign o_Cur_Src    = cur_src_r;
    assign o_Pend_Valid = pend_valid_r;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter at CLK_HZ=100000 (1 ms = 100 cycles); jingle notes shortened to 50 ms.
module tb_sfx_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] game_cmd;
    logic       click;
    logic       jingle;
    logic       mute;
    logic       buzzer;
    logic       playing;
    logic [2:0] cur_src;
    logic       pend_valid;

    int checks   = 0;
    int failures = 0;
    int buz_hi   = 0;
    int play_hi  = 0;
    int play_lo  = 0;

    typedef struct {
        string      name;
        logic       click;
        logic [1:0] cmd;
        logic       jingle;
        logic       mute;
        int         wait_n;
        logic       exp_play;
        logic [2:0] exp_src;
        logic       exp_pend;
        logic       chk_buz;
        logic       exp_buz;
        logic       quiet_buz;
        logic       quiet_play;
    } vec_t;

    vec_t vq[$];

    sfx_arbiter #(
        .CLK_HZ  (100_000),
        .NOTE_MS (50)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Game_Cmd   (game_cmd),
        .i_Click      (click),
        .i_Jingle     (jingle),
        .i_Mute       (mute),
        .o_Buzzer     (buzzer),
        .o_Playing    (playing),
        .o_Cur_Src    (cur_src),
        .o_Pend_Valid (pend_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            if (buzzer) buz_hi++;
            if (playing) play_hi++;
            else play_lo++;
        end
    endtask

    task automatic pulse(input logic c, input logic [1:0] cmd, input logic j);
        click    = c;
        game_cmd = cmd;
        jingle   = j;
        tick();
        click    = 1'b0;
        game_cmd = 2'd0;
        jingle   = 1'b0;
    endtask

    task automatic outs(input string tag, input int p, input int s, input int pv, input int b);
        check({tag, ".play"}, int'(playing), p);
        check({tag, ".src"}, int'(cur_src), s);
        check({tag, ".pend"}, int'(pend_valid), pv);
        check({tag, ".buz"}, int'(buzzer), b);
    endtask

    task automatic add_vec(input string n, input logic c, input logic [1:0] cmd, input logic j,
                           input logic m, input int w, input logic ep, input logic [2:0] es,
                           input logic epd, input logic cb, input logic eb, input logic qb, input logic qp);
        vec_t v;
        v.name = n; v.click = c; v.cmd = cmd; v.jingle = j; v.mute = m; v.wait_n = w;
        v.exp_play = ep; v.exp_src = es; v.exp_pend = epd;
        v.chk_buz = cb; v.exp_buz = eb; v.quiet_buz = qb; v.quiet_play = qp;
        vq.push_back(v);
    endtask

    initial begin
        rst = 1'b1; game_cmd = 2'd0; click = 1'b0; jingle = 1'b0; mute = 1'b0;

        // Arbitration table: click, miss preempts, perfect then good pend, click dropped,
        // good plays after miss + gap with mute held, then idle with no resumed click.
        add_vec("click_start",    1'b1, 2'd0, 1'b0, 1'b0, 1,     1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("click_mid",      1'b0, 2'd0, 1'b0, 1'b0, 99,    1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("miss_preempt",   1'b0, 2'd3, 1'b0, 1'b0, 1,     1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("perfect_pend",   1'b0, 2'd1, 1'b0, 1'b0, 1,     1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("good_overwrite", 1'b0, 2'd2, 1'b0, 1'b0, 1,     1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("click_dropped",  1'b1, 2'd0, 1'b0, 1'b0, 1,     1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("miss_hp_before", 1'b0, 2'd0, 1'b0, 1'b0, 223,   1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("miss_hp_edge",   1'b0, 2'd0, 1'b0, 1'b0, 1,     1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec("miss_last",      1'b0, 2'd0, 1'b0, 1'b0, 19772, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("miss_done",      1'b0, 2'd0, 1'b0, 1'b0, 1,     1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("gap_hold",       1'b0, 2'd0, 1'b0, 1'b0, 999,   1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        add_vec("good_from_pend", 1'b0, 2'd0, 1'b0, 1'b0, 1,     1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("good_muted",     1'b0, 2'd0, 1'b0, 1'b1, 5999,  1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec("good_done",      1'b0, 2'd0, 1'b0, 1'b1, 1,     1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("back_to_idle",   1'b0, 2'd0, 1'b0, 1'b0, 1000,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset state and 1000 quiet cycles
        repeat (3) tick();
        outs("reset", 0, 0, 0, 0);
        rst = 1'b0;
        buz_hi = 0; play_hi = 0;
        adv(1000);
        outs("idle1000", 0, 0, 0, 0);
        check("idle1000.buz_hi", buz_hi, 0);
        check("idle1000.play_hi", play_hi, 0);

        for (int i = 0; i < vq.size(); i++) begin
            click = vq[i].click; game_cmd = vq[i].cmd; jingle = vq[i].jingle; mute = vq[i].mute;
            buz_hi = 0; play_hi = 0;
            for (int c = 0; c < vq[i].wait_n; c++) begin
                tick();
                click = 1'b0; game_cmd = 2'd0; jingle = 1'b0;
                if (buzzer) buz_hi++;
                if (playing) play_hi++;
            end
            check({vq[i].name, ".play"}, int'(playing), int'(vq[i].exp_play));
            check({vq[i].name, ".src"}, int'(cur_src), int'(vq[i].exp_src));
            check({vq[i].name, ".pend"}, int'(pend_valid), int'(vq[i].exp_pend));
            if (vq[i].chk_buz) check({vq[i].name, ".buz"}, int'(buzzer), int'(vq[i].exp_buz));
            if (vq[i].quiet_buz) check({vq[i].name, ".buz_hi"}, buz_hi, 0);
            if (vq[i].quiet_play) check({vq[i].name, ".play_hi"}, play_hi, 0);
        end
        mute = 1'b0;

        // Jingle + click together: 4 notes back-to-back (5000 cycles each), gap, then click
        pulse(1'b1, 2'd0, 1'b1);
        outs("jingle_start", 1, 5, 1, 0);
        adv(94);   check("j_note0_pre", int'(buzzer), 0);
        adv(1);    check("j_note0_rise", int'(buzzer), 1);
        play_lo = 0;
        adv(4904); check("j_note0_last.src", int'(cur_src), 5);
        adv(1);    outs("j_note1_start", 1, 5, 1, 0);
        adv(74);   check("j_note1_pre", int'(buzzer), 0);
        adv(1);    check("j_note1_rise", int'(buzzer), 1);
        adv(14924);
        outs("j_last", 1, 5, 1, int'(buzzer));
        check("j_no_gap.play_lo", play_lo, 0);
        adv(1);    outs("j_done", 0, 0, 1, 0);
        play_hi = 0;
        adv(999);  check("j_gap.play_hi", play_hi, 0);
        adv(1);    outs("click_after_j", 1, 1, 0, 0);
        adv(24);   check("click_pre_rise", int'(buzzer), 0);
        adv(1);    check("click_rise", int'(buzzer), 1);
        adv(25);   check("click_fall", int'(buzzer), 0);
        adv(25);   check("click_rise2", int'(buzzer), 1);
        adv(1924); check("click_last.play", int'(playing), 1);
        adv(1);    outs("click_end", 0, 0, 0, 0);
        play_hi = 0;
        adv(1200); check("click_never_again.play_hi", play_hi, 0);

        // Jingle restart during jingle, then synchronous reset mid-jingle
        pulse(1'b0, 2'd0, 1'b1);
        adv(299);
        pulse(1'b0, 2'd0, 1'b1);
        outs("j_restart", 1, 5, 0, 0);
        adv(94);   check("j_restart_pre", int'(buzzer), 0);
        adv(1);    check("j_restart_rise", int'(buzzer), 1);
        pulse(1'b0, 2'd1, 1'b0);
        outs("j_pend_perfect", 1, 5, 1, int'(buzzer));
        adv(10);
        rst = 1'b1;
        tick();
        outs("mid_reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        outs("post_reset", 0, 0, 0, 0);
        pulse(1'b1, 2'd0, 1'b0);
        outs("post_reset_click", 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
